// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, sequencer state, and the 4 KB page
// constant used by the address-channel legality checks.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_RESERVED = 2'b10,
    BURST_WRAP     = 2'b11
  } burst_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int unsigned BOUNDARY_4K = 4096;

  // WRAP bursts must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/faxi_address.sv
// Combinational AXI next-beat address calculator. Aligns to the beat size for
// INCR/WRAP, wraps inside the (len+1)<<size window for WRAP, holds for FIXED.
module faxi_address
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  burst_t        burst,
  input  logic [7:0]    len,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] bytes;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;

  always_comb begin
    bytes     = AW'(1) << size;
    aligned   = addr & ~(bytes - AW'(1));
    incr_addr = aligned + bytes;
    wrap_mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_sequencer.sv
// Turns one AXI address-channel burst descriptor into a stream of per-beat
// addresses, with legality checks and bubble-free back-to-back bursts.
module axi_burst_sequencer
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int IW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_avalid,
  output logic          o_aready,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_len,
  input  logic [2:0]    i_size,
  input  logic [1:0]    i_burst,
  input  logic [IW-1:0] i_id,
  output logic          o_beat_valid,
  input  logic          i_beat_ready,
  output logic [AW-1:0] o_beat_addr,
  output logic          o_beat_last,
  output logic [IW-1:0] o_beat_id,
  output logic          o_busy,
  output logic          o_err,
  output state_t        o_state
);

  // Handshakes: a descriptor transfers on a clock edge where i_avalid && o_aready,
  // a beat transfers where o_beat_valid && i_beat_ready; valid never waits on ready.
  state_t        state;
  logic [7:0]    beats_left;
  logic [2:0]    size_q;
  logic [7:0]    len_q;
  burst_t        burst_q;
  logic [AW-1:0] next_addr;

  logic          accept;
  logic          beat_hs;
  burst_t        burst_in;
  burst_t        burst_eff;
  logic [11:0]   size_mask;
  logic [11:0]   page_start;
  logic [17:0]   page_end;
  logic          wrap_bad;
  logic          rsvd_bad;
  logic          fixed_bad;
  logic          incr_cross;
  logic          illegal;

  assign beat_hs  = o_beat_valid && i_beat_ready;
  // Ready also opens on the final beat handshake so the next burst has no bubble.
  assign o_aready = !i_reset && ((state == ST_IDLE) || (beat_hs && o_beat_last));
  assign accept   = i_avalid && o_aready;
  assign o_busy   = (state == ST_BURST);
  assign o_state  = state;

  always_comb begin
    burst_in   = burst_t'(i_burst);
    size_mask  = 12'((13'd1 << i_size) - 13'd1);
    page_start = i_addr[11:0] & ~size_mask;
    page_end   = 18'(page_start) + ((18'(i_len) + 18'd1) << i_size);
    wrap_bad   = (burst_in == BURST_WRAP) && !wrap_len_ok(i_len);
    rsvd_bad   = (burst_in == BURST_RESERVED);
    fixed_bad  = (burst_in == BURST_FIXED) && (i_len > 8'd15);
    incr_cross = (burst_in == BURST_INCR) && (page_end > 18'(BOUNDARY_4K));
    burst_eff  = (wrap_bad || rsvd_bad) ? BURST_INCR : burst_in;
    illegal    = wrap_bad || rsvd_bad || fixed_bad || incr_cross;
  end

  faxi_address #(
    .AW(AW)
  ) u_faxi_address (
    .addr      (o_beat_addr),
    .size      (size_q),
    .burst     (burst_q),
    .len       (len_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      o_beat_valid <= 1'b0;
      o_beat_last  <= 1'b0;
      o_beat_addr  <= '0;
      o_beat_id    <= '0;
      o_err        <= 1'b0;
      beats_left   <= 8'd0;
      size_q       <= 3'd0;
      len_q        <= 8'd0;
      burst_q      <= BURST_FIXED;
    end else begin
      o_err <= 1'b0;
      if (accept) begin
        state        <= ST_BURST;
        o_beat_valid <= 1'b1;
        o_beat_addr  <= i_addr;
        o_beat_last  <= (i_len == 8'd0);
        o_beat_id    <= i_id;
        beats_left   <= i_len;
        size_q       <= i_size;
        len_q        <= i_len;
        burst_q      <= burst_eff;
        o_err        <= illegal;
      end else if (beat_hs) begin
        if (o_beat_last) begin
          state        <= ST_IDLE;
          o_beat_valid <= 1'b0;
          o_beat_last  <= 1'b0;
        end else begin
          o_beat_addr <= next_addr;
          beats_left  <= beats_left - 8'd1;
          o_beat_last <= (beats_left == 8'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_sequencer.sv
// Directed and randomised bench for axi_burst_sequencer with an expected-beat
// queue filled from an independent address model.
module tb_axi_burst_sequencer;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int W  = 1 + IW + AW;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_avalid;
  logic          o_aready;
  logic [AW-1:0] i_addr;
  logic [7:0]    i_len;
  logic [2:0]    i_size;
  logic [1:0]    i_burst;
  logic [IW-1:0] i_id;
  logic          o_beat_valid;
  logic          i_beat_ready;
  logic [AW-1:0] o_beat_addr;
  logic          o_beat_last;
  logic [IW-1:0] o_beat_id;
  logic          o_busy;
  logic          o_err;
  state_t        o_state;

  always #5 i_clk = ~i_clk;

  axi_burst_sequencer #(.AW(AW), .IW(IW)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_avalid     (i_avalid),
    .o_aready     (o_aready),
    .i_addr       (i_addr),
    .i_len        (i_len),
    .i_size       (i_size),
    .i_burst      (i_burst),
    .i_id         (i_id),
    .o_beat_valid (o_beat_valid),
    .i_beat_ready (i_beat_ready),
    .o_beat_addr  (o_beat_addr),
    .o_beat_last  (o_beat_last),
    .o_beat_id    (o_beat_id),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .o_state      (o_state)
  );

  logic [W-1:0] exp_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           hs_count   = 0;
  logic         err_exp    = 1'b0;
  logic         desc_err   = 1'b0;
  logic         toggle_ready = 1'b0;
  logic         rand_ready   = 1'b0;
  logic         held_v     = 1'b0;
  logic [W:0]   held       = '0;
  logic         accepted   = 1'b0;
  logic         b2b_seen   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] start, input int len,
                                               input int size, input burst_t b, input int i);
    longint unsigned bytes, aligned, wrap, lower;
    bytes   = longint'(1) << size;
    aligned = (longint'(start) / bytes) * bytes;
    if (i == 0 || b == BURST_FIXED) return start;
    if (b == BURST_WRAP) begin
      wrap  = longint'(len + 1) * bytes;
      lower = (longint'(start) / wrap) * wrap;
      return AW'(lower + ((aligned - lower + longint'(i) * bytes) % wrap));
    end
    return AW'(aligned + longint'(i) * bytes);
  endfunction

  // One clock: observe at the falling edge, then drive just after the rising edge.
  task automatic cycle();
    logic acc;
    @(negedge i_clk);
    check("err", o_err, err_exp);
    if (held_v) check("hold", {o_beat_valid, o_beat_last, o_beat_id, o_beat_addr}, held);
    if (o_beat_valid && i_beat_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_beat observed=0x%0h expected=no beat", o_beat_addr);
      end else begin
        check("beat", {o_beat_last, o_beat_id, o_beat_addr}, exp_q.pop_front());
      end
    end
    held_v = o_beat_valid && !i_beat_ready && !i_reset;
    held   = {o_beat_valid, o_beat_last, o_beat_id, o_beat_addr};
    acc    = i_avalid && o_aready;
    if (acc && o_beat_valid && o_beat_last) b2b_seen = 1'b1;
    @(posedge i_clk);
    #1;
    err_exp  = acc ? desc_err : 1'b0;
    accepted = acc;
    if (toggle_ready) i_beat_ready = ~i_beat_ready;
    else if (rand_ready) i_beat_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_desc(input logic [AW-1:0] addr, input int len, input int size,
                           input logic [1:0] burst, input logic [IW-1:0] id,
                           input burst_t eff, input logic err);
    for (int i = 0; i <= len; i++)
      exp_q.push_back({(i == len), id, model_addr(addr, len, size, eff, i)});
    i_addr   = addr;
    i_len    = 8'(len);
    i_size   = 3'(size);
    i_burst  = burst;
    i_id     = id;
    desc_err = err;
    i_avalid = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 64 && !accepted; t++) cycle();
    compared++;
    assert (accepted) else begin
      mismatched++;
      $error("FAIL accept_timeout observed=not accepted expected=accepted");
    end
    i_avalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (exp_q.size() != 0 || o_beat_valid); t++) cycle();
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0;
    logic [AW-1:0] ra;
    int rl, rs, kind;
    i_reset = 1'b1; i_avalid = 1'b0; i_addr = '0; i_len = '0; i_size = '0;
    i_burst = '0; i_id = '0; i_beat_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("rst_valid", o_beat_valid, 1'b0);
    check("rst_last", o_beat_last, 1'b0);
    check("rst_addr", o_beat_addr, 32'h0);
    check("rst_id", o_beat_id, 4'h0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_aready", o_aready, 1'b0);
    check("rst_state", o_state, ST_IDLE);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check("idle_aready", o_aready, 1'b1);
    @(posedge i_clk);
    #1;
    i_beat_ready = 1'b1;

    send_desc(32'h1000, 3, 2, BURST_INCR, 4'd1, BURST_INCR, 1'b0);
    check("busy_on", o_busy, 1'b1);
    check("state_burst", o_state, ST_BURST);
    drain();
    check("busy_off", o_busy, 1'b0);

    send_desc(32'h18, 3, 3, BURST_WRAP, 4'd2, BURST_WRAP, 1'b0);
    send_desc(32'h40, 2, 2, BURST_FIXED, 4'd3, BURST_FIXED, 1'b0);
    drain();

    toggle_ready = 1'b1;
    send_desc(32'h1003, 1, 2, BURST_INCR, 4'd4, BURST_INCR, 1'b0);
    send_desc(32'h34, 3, 2, BURST_WRAP, 4'd9, BURST_WRAP, 1'b0);
    drain();
    toggle_ready = 1'b0;
    i_beat_ready = 1'b1;

    b2b_seen = 1'b0;
    send_desc(32'h200, 0, 2, BURST_INCR, 4'd5, BURST_INCR, 1'b0);
    send_desc(32'h300, 1, 2, BURST_INCR, 4'd6, BURST_INCR, 1'b0);
    check("b2b_accept", b2b_seen, 1'b1);
    hs0 = hs_count;
    cycle();
    cycle();
    check("no_bubble", 64'(hs_count - hs0), 64'd2);
    drain();

    send_desc(32'h10, 2, 2, BURST_WRAP, 4'd1, BURST_INCR, 1'b1);
    send_desc(32'hFF8, 1, 3, BURST_INCR, 4'd2, BURST_INCR, 1'b1);
    send_desc(32'h80, 1, 2, BURST_RESERVED, 4'd3, BURST_INCR, 1'b1);
    send_desc(32'h5, 16, 0, BURST_FIXED, 4'd4, BURST_FIXED, 1'b1);
    drain();

    rand_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      kind = $urandom_range(0, 2);
      rs   = $urandom_range(0, 2);
      ra   = (AW'($urandom_range(0, 1023)) << 12) | (AW'($urandom_range(0, 240)) << 4)
             | AW'($urandom_range(0, 3));
      if (kind == 1) begin
        rl = (1 << $urandom_range(1, 3)) - 1;
        send_desc(ra, rl, rs, BURST_WRAP, 4'(n), BURST_WRAP, 1'b0);
      end else if (kind == 2) begin
        rl = $urandom_range(0, 7);
        send_desc(ra, rl, rs, BURST_FIXED, 4'(n), BURST_FIXED, 1'b0);
      end else begin
        rl = $urandom_range(0, 7);
        send_desc(ra, rl, rs, BURST_INCR, 4'(n), BURST_INCR, 1'b0);
      end
    end
    rand_ready   = 1'b0;
    i_beat_ready = 1'b1;
    drain();

    send_desc(32'h2000, 7, 2, BURST_INCR, 4'd7, BURST_INCR, 1'b0);
    for (int t = 0; t < 20 && exp_q.size() > 6; t++) cycle();
    check("beat2_addr", o_beat_addr, 32'h2008);
    i_reset      = 1'b1;
    i_beat_ready = 1'b0;
    @(negedge i_clk);
    check("rst_mid_aready", o_aready, 1'b0);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("rst_mid_valid", o_beat_valid, 1'b0);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_last", o_beat_last, 1'b0);
    @(posedge i_clk);
    #1;
    exp_q.delete();
    held_v       = 1'b0;
    err_exp      = 1'b0;
    i_reset      = 1'b0;
    i_beat_ready = 1'b1;
    send_desc(32'h3000, 1, 2, BURST_INCR, 4'd8, BURST_INCR, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
